// File: rtl/uart_buffer_pkg.sv
// uart_buffer_pkg: shared word width, UART size encodings and FSM states
package uart_buffer_pkg;
  localparam int LEN_WORD = 32;
  localparam logic [1:0] SIZE_1B = 2'b00;
  localparam logic [1:0] SIZE_2B = 2'b01;
  localparam logic [1:0] SIZE_4B = 2'b10;
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    return size == SIZE_1B ? 2'd0 : size == SIZE_2B ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/uart_buffer_byte_fifo.sv
// byte_fifo: byte-wide FIFO with wrap-bit pointers and a combinational head
module byte_fifo #(
  parameter int DEPTH_LOG = 9
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  logic [DEPTH_LOG:0] wp, rp;
  logic [7:0] mem [2**DEPTH_LOG];
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = wp[DEPTH_LOG] != rp[DEPTH_LOG] && wp[DEPTH_LOG-1:0] == rp[DEPTH_LOG-1:0];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp[DEPTH_LOG-1:0]];
  // pointer update; a push while full is refused even if a pop frees space this cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  // storage, not reset: contents are only visible through the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[DEPTH_LOG-1:0]] <= din;
  end
endmodule

// File: rtl/uart_buffer.sv
// uart_buffer: turns CPU word requests into TX/RX byte FIFO traffic
module uart_buffer #(
  parameter int DEPTH_LOG = 9,
  parameter int LEN_WORD  = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                uart_order,
  input  logic                uart_write_flag,
  input  logic [1:0]          uart_size,
  input  logic [LEN_WORD-1:0] uart_o_data,
  output logic [LEN_WORD-1:0] uart_i_data,
  output logic                uart_accepted,
  output logic                uart_accessed,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_overflow
);
  import uart_buffer_pkg::*;
  state_t state, state_nx;
  logic [1:0] cnt, last;
  logic [LEN_WORD-1:0] data, asm_w;
  logic [7:0] rx_dout;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic order, tx_push, rx_pop, done;
  assign order = state == IDLE && uart_order;
  assign tx_push = state == WRITE && !tx_full;
  assign rx_pop = state == READ && !rx_empty;
  assign done = (tx_push || rx_pop) && cnt == last;
  assign tx_valid = !tx_empty;
  byte_fifo #(.DEPTH_LOG(DEPTH_LOG)) u_tx (
    .clk(clk), .rstn(rstn), .push(tx_push), .din(data[{cnt, 3'b000} +: 8]),
    .pop(tx_ready), .dout(tx_data), .full(tx_full), .empty(tx_empty)
  );
  byte_fifo #(.DEPTH_LOG(DEPTH_LOG)) u_rx (
    .clk(clk), .rstn(rstn), .push(rx_valid), .din(rx_data),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );
  // state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  end
  // next state: orders only start from IDLE, the last byte returns to IDLE
  always_comb begin
    state_nx = state;
    if (order) state_nx = uart_write_flag ? WRITE : READ;
    else if (done) state_nx = IDLE;
  end
  // request latch, byte counter, read assembly and handshake pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
      last <= '0;
      data <= '0;
      asm_w <= '0;
      uart_i_data <= '0;
      uart_accepted <= 1'b0;
      uart_accessed <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      uart_accepted <= order;
      uart_accessed <= done;
      if (rx_valid && rx_full) rx_overflow <= 1'b1;
      if (order) begin
        last <= last_idx(uart_size);
        data <= uart_o_data;
        cnt <= '0;
        asm_w <= '0;
      end else if (tx_push || rx_pop) cnt <= cnt + 1'b1;
      if (rx_pop) asm_w[{cnt, 3'b000} +: 8] <= rx_dout;
      if (rx_pop && cnt == last) uart_i_data <= asm_w | (LEN_WORD'(rx_dout) << {cnt, 3'b000});
    end
  end
endmodule

// File: tb/tb_uart_buffer.sv
// tb_uart_buffer: scoreboard bench for uart_buffer with directed vectors
module tb_uart_buffer;
  logic clk = 0, rstn = 0, uart_order = 0, uart_write_flag = 0;
  logic [1:0] uart_size = 0;
  logic [31:0] uart_o_data = 0, uart_i_data;
  logic uart_accepted, uart_accessed, tx_valid, rx_overflow;
  logic tx_ready = 0, rx_valid = 0;
  logic [7:0] tx_data, rx_data = 0;

  uart_buffer dut (
    .clk(clk), .rstn(rstn), .uart_order(uart_order), .uart_write_flag(uart_write_flag),
    .uart_size(uart_size), .uart_o_data(uart_o_data), .uart_i_data(uart_i_data),
    .uart_accepted(uart_accepted), .uart_accessed(uart_accessed), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {logic rd; logic [31:0] data; int cyc;} exp_t;
  exp_t acc_q[$];
  exp_t e;
  int accp_q[$];
  logic [7:0] tx_q[$];
  int nvec = 0, nerr = 0, n_done = 0, last_t = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: output seen with nothing expected", name);
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [7:0] pat(input int i);
    return i[7:0] ^ 8'h5A;
  endfunction

  // monitor: cycle number of the period after edge k is k+1
  always @(negedge clk) begin
    if (uart_accepted === 1'b1) begin
      if (accp_q.size() == 0) flag("accepted_unexpected");
      else chk("accepted_cycle", edge_n + 1, accp_q.pop_front());
    end
    if (uart_accessed === 1'b1) begin
      n_done++;
      if (acc_q.size() == 0) flag("accessed_unexpected");
      else begin
        e = acc_q.pop_front();
        if (e.cyc >= 0) chk("accessed_cycle", edge_n + 1, e.cyc);
        if (e.rd) chk("read_data", uart_i_data, e.data);
      end
    end
    if (uart_accepted === 1'b1 && uart_accessed === 1'b1) flag("accepted_accessed_overlap");
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (tx_q.size() == 0) flag("tx_unexpected");
      else chk("tx_byte", tx_data, tx_q.pop_front());
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] d,
                       input int lat, input logic [31:0] rd_exp, input logic fin);
    exp_t x;
    step;
    uart_order = 1;
    uart_write_flag = wr;
    uart_size = sz;
    uart_o_data = d;
    last_t = edge_n + 1;
    accp_q.push_back(last_t + 1);
    if (fin) begin
      x.rd = !wr;
      x.data = rd_exp;
      x.cyc = lat < 0 ? -1 : last_t + lat;
      acc_q.push_back(x);
      if (wr) for (int i = 0; i < nbytes(sz); i++) tx_q.push_back(d[8*i +: 8]);
    end
    step;
    uart_order = 0;
  endtask

  task automatic wait_done(input int tgt, input int budget);
    int k = 0;
    while (n_done < tgt && k < budget) begin
      step;
      k++;
    end
    chk("done_count", n_done, tgt);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (tx_q.size() > 0 && k < budget) begin
      step;
      k++;
    end
    step;
    chk("tx_drained", tx_q.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_i_data"}, uart_i_data, 0);
    chk({tag, "_accepted"}, uart_accepted, 0);
    chk({tag, "_accessed"}, uart_accessed, 0);
    chk({tag, "_overflow"}, rx_overflow, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
  endtask

  initial begin
    int base;
    repeat (3) step;
    check_reset("reset");
    rstn = 1;
    step;
    // 1: 4-byte write, bytes leave little-endian
    tx_ready = 1;
    issue(1, 2'b10, 32'hDEADBEEF, 5, 0, 1);
    wait_done(1, 20);
    drain(20);
    // 2: 2-byte read from a preloaded RX FIFO
    step;
    rx_valid = 1;
    rx_data = 8'h34;
    step;
    rx_data = 8'h12;
    step;
    rx_valid = 0;
    issue(0, 2'b01, 0, 3, 32'h00001234, 1);
    wait_done(2, 20);
    // 3: 4-byte read waiting on slow bytes; a stray order mid-read is ignored
    issue(0, 2'b10, 0, 42, 32'h04030201, 1);
    base = last_t;
    for (int k = 1; k <= 4; k++) begin
      while (edge_n < base + 10 * k - 1) step;
      rx_valid = 1;
      rx_data = 8'(k);
      uart_order = k == 2;
      uart_write_flag = 1;
      step;
      rx_valid = 0;
      uart_order = 0;
    end
    wait_done(3, 20);
    // 4: fill TX FIFO with tx_ready low, then one stalled write
    tx_ready = 0;
    for (int i = 0; i < 512; i++) begin
      issue(1, 2'b00, 32'(i & 255), 2, 0, 1);
      wait_done(4 + i, 20);
    end
    issue(1, 2'b00, 32'h000000C3, -1, 0, 1);
    repeat (30) step;
    chk("stall_no_accessed", n_done, 515);
    chk("tx_valid_full", tx_valid, 1);
    tx_ready = 1;
    wait_done(516, 50);
    drain(600);
    // 5: fill RX FIFO, overflow byte dropped, overflow sticky
    step;
    rx_valid = 1;
    for (int i = 0; i < 512; i++) begin
      rx_data = pat(i);
      step;
    end
    chk("overflow_before", rx_overflow, 0);
    rx_data = 8'hAA;
    step;
    rx_valid = 0;
    step;
    chk("overflow_set", rx_overflow, 1);
    for (int w = 0; w < 128; w++) begin
      issue(0, 2'b10, 0, 5, {pat(4*w+3), pat(4*w+2), pat(4*w+1), pat(4*w)}, 1);
      wait_done(517 + w, 20);
    end
    chk("overflow_sticky", rx_overflow, 1);
    issue(0, 2'b00, 0, -1, 32'h00000077, 1);
    repeat (20) step;
    chk("rx_empty_waits", n_done, 644);
    rx_valid = 1;
    rx_data = 8'h77;
    step;
    rx_valid = 0;
    wait_done(645, 20);
    // 6: reset in the middle of a 4-byte write
    tx_ready = 0;
    issue(1, 2'b10, 32'h11223344, -1, 0, 0);
    step;
    step;
    rstn = 0;
    step;
    step;
    check_reset("midreset");
    rstn = 1;
    step;
    tx_ready = 1;
    repeat (5) step;
    chk("tx_lost_after_reset", tx_valid, 0);
    chk("no_accessed_after_abort", n_done, 645);
    issue(1, 2'b01, 32'h0000BEEF, 3, 0, 1);
    wait_done(646, 20);
    issue(1, 2'b11, 32'hA1B2C3D4, 5, 0, 1);
    wait_done(647, 20);
    drain(50);
    chk("accessed_queue_empty", acc_q.size(), 0);
    chk("accepted_queue_empty", accp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the end of the run");
    $fatal(1);
  end
endmodule
